// File: rtl/db_pkg.sv
// Shared constants for the key/value DRAM path.
// Source tags and default DRAM geometry.
package db_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEF_RAM_ADDR   = 22;
  localparam int DEF_RAM_DWIDTH = 32;
  localparam int DEF_MAX_OUTSTD = 4;

endpackage

// File: rtl/db_tag_fifo.sv
// Tag FIFO recording the source of each read in flight.
// One bit wide, power-of-two deep, pointers wrap naturally.
module db_tag_fifo
  import db_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTD,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        din,
  input  logic        pop,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; overflow and
  // underflow requests are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count
             + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/db_dram_arb.sv
// Two-port round-robin arbiter onto the DRAM PHY command port.
// Reads are tagged so in-order returns reach their requester.
module db_dram_arb
  import db_pkg::*;
#(
  parameter int RAM_ADDR   = DEF_RAM_ADDR,
  parameter int RAM_DWIDTH = DEF_RAM_DWIDTH,
  parameter int MAX_OUTSTD = DEF_MAX_OUTSTD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [RAM_ADDR-1:0]   a_addr,
  input  logic [RAM_DWIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [RAM_DWIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [RAM_ADDR-1:0]   b_addr,
  input  logic [RAM_DWIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [RAM_DWIDTH-1:0] b_rdata,
  output logic                  dram_wr_en,
  output logic                  dram_rd_en,
  output logic [RAM_ADDR-1:0]   dram_addr,
  output logic [RAM_DWIDTH-1:0] dram_wr_din,
  input  logic                  dram_rd_valid,
  input  logic [RAM_DWIDTH-1:0] dram_rd_dout,
  output logic                  rd_err
);

  localparam int CW = $clog2(MAX_OUTSTD) + 1;

  logic [CW-1:0]         cnt;
  logic                  slot_free;
  logic                  a_elig;
  logic                  b_elig;
  logic                  both;
  logic                  a_only;
  logic                  b_only;
  logic                  rr_last;
  logic                  gnt;
  logic                  sel_we;
  logic [RAM_ADDR-1:0]   sel_addr;
  logic [RAM_DWIDTH-1:0] sel_wdata;
  logic                  tag_push;
  logic                  tag_src;
  logic                  tag_full;
  logic                  tag_empty;
  logic                  ret_ok;

  // Nothing is accepted while reset is held.
  assign slot_free = (cnt < CW'(MAX_OUTSTD));
  assign a_elig = rst & a_req & (a_we | slot_free);
  assign b_elig = rst & b_req & (b_we | slot_free);
  assign both   = a_elig & b_elig;
  assign a_only = a_elig & ~b_elig;
  assign b_only = b_elig & ~a_elig;

  // Grant decode: conflicts go to the port not served last.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    unique case (1'b1)
      both: begin
        if (rr_last == SRC_B) a_gnt = 1'b1;
        else                  b_gnt = 1'b1;
      end
      a_only:  a_gnt = 1'b1;
      b_only:  b_gnt = 1'b1;
      default: ;
    endcase
  end

  assign gnt       = a_gnt | b_gnt;
  assign sel_we    = b_gnt ? b_we    : a_we;
  assign sel_addr  = b_gnt ? b_addr  : a_addr;
  assign sel_wdata = b_gnt ? b_wdata : a_wdata;
  assign tag_push  = gnt & ~sel_we & ~tag_full;
  assign ret_ok    = dram_rd_valid & ~tag_empty;

  db_tag_fifo #(
    .DEPTH (MAX_OUTSTD)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (tag_push),
    .din   (b_gnt),
    .pop   (dram_rd_valid),
    .dout  (tag_src),
    .full  (tag_full),
    .empty (tag_empty),
    .count (cnt)
  );

  // Issue register: one-cycle strobes, address/data
  // held between grants, round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dram_wr_en  <= 1'b0;
      dram_rd_en  <= 1'b0;
      dram_addr   <= '0;
      dram_wr_din <= '0;
      rr_last     <= SRC_B;
    end else begin
      dram_wr_en <= gnt & sel_we;
      dram_rd_en <= gnt & ~sel_we;
      if (gnt) begin
        dram_addr   <= sel_addr;
        dram_wr_din <= sel_wdata;
        rr_last     <= b_gnt ? SRC_B : SRC_A;
      end
    end
  end

  // Return register: route by popped tag, flag
  // returns that arrive with nothing outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      rd_err   <= 1'b0;
    end else begin
      a_rvalid <= ret_ok & (tag_src == SRC_A);
      b_rvalid <= ret_ok & (tag_src == SRC_B);
      if (ret_ok && tag_src == SRC_A) begin
        a_rdata <= dram_rd_dout;
      end
      if (ret_ok && tag_src == SRC_B) begin
        b_rdata <= dram_rd_dout;
      end
      if (dram_rd_valid && tag_empty) begin
        rd_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/db_dram_arb.md
Name: db_dram_arb

Overview:
- Shares the single DRAM PHY command port between two key/value requesters: port A (lookup path from db_cont, read-mostly) and port B (insert/update/expiry path, write-mostly).
- Round-robin arbitration with one command per cycle and an outstanding-read limit.
- In-order read returns are routed back to the issuing requester through a tag FIFO.
- Sits between db_cont and dram_phy inside db_top.

Parameters:
- RAM_ADDR, 22: DRAM word address width.
- RAM_DWIDTH, 32: DRAM data width.
- MAX_OUTSTD, 4: maximum reads in flight; power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- a_req  in  1  port A command request
- a_we  in  1  1=write, 0=read
- a_addr  in  RAM_ADDR  address
- a_wdata  in  RAM_DWIDTH  write data
- a_gnt  out  1  combinational; command accepted this cycle
- a_rvalid  out  1  read data valid, one-cycle pulse
- a_rdata  out  RAM_DWIDTH  read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- dram_wr_en  out  1  registered write strobe
- dram_rd_en  out  1  registered read strobe
- dram_addr  out  RAM_ADDR  registered address
- dram_wr_din  out  RAM_DWIDTH  registered write data
- dram_rd_valid  in  1  read return valid; returns are in order
- dram_rd_dout  in  RAM_DWIDTH  read return data
- rd_err  out  1  sticky; dram_rd_valid arrived with no read outstanding

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, tag FIFO empty, outstanding count 0, rr_last=B (so A wins the first conflict).
- Eligibility: a port is eligible when req=1 and (we=1 or cnt<MAX_OUTSTD). cnt is the registered value; a same-cycle pop does not free a slot.
- Arbitration, per cycle:
  - one eligible port: that port is granted.
  - both eligible: the port != rr_last is granted.
  - rr_last updates only on a grant.
  - at most one gnt is high per cycle.
- Requester holds req/we/addr/wdata stable until gnt. Deasserting req without a grant is legal; nothing is issued.
- Issue: command granted in cycle N appears on dram_* in cycle N+1 for exactly one cycle. No grant means wr_en=rd_en=0, and addr/din hold their last value.
- Read tag:
  - a granted read pushes its source (0=A, 1=B) into the tag FIFO in cycle N and increments cnt.
  - dram_rd_valid pops the FIFO and decrements cnt.
  - push and pop in the same cycle leave cnt unchanged.
- Return: dram_rd_valid in cycle M produces {a|b}_rvalid=1 in cycle M+1, carrying rdata=dram_rd_dout registered at M, routed by the popped tag. The other port's rvalid stays 0. rdata holds between pulses.
- Empty-FIFO return: rd_valid with cnt=0 is dropped. No rvalid, rd_err<=1 until reset, and cnt stays 0 (no underflow).
- cnt=MAX_OUTSTD: reads stall; writes keep flowing, so a write on the other port is granted even if it lost round-robin.
- Ordering: no reordering within a port. Cross-port read-after-write ordering follows grant order only; no hazard checking is done.
- Arithmetic: cnt is clog2(MAX_OUTSTD)+1 bits and never exceeds MAX_OUTSTD. FIFO pointers wrap modulo MAX_OUTSTD.

Decomposition:
- db_pkg holds:
  - constants SRC_A=1'b0, SRC_B=1'b1;
  - RAM_ADDR/RAM_DWIDTH defaults shared with db_cont and dram_phy;
  - the MAX_OUTSTD default.
- Sub-module: db_tag_fifo, 1-bit wide, MAX_OUTSTD deep, synchronous push/pop, full/empty/count outputs, asynchronous active-low reset.
- Arbiter, issue register and return register stay in db_dram_arb.

Test Plan:
- Single read: a_req=1, a_we=0, a_addr=0x000010 at cycle 5.
  - a_gnt=1 @5; dram_rd_en=1, dram_addr=0x10 @6.
  - drive rd_valid, dout=0xDEADBEEF @9 -> a_rvalid=1, a_rdata=0xDEADBEEF @10; b_rvalid=0.
- Conflict fairness: A read and B write held for 4 cycles after reset.
  - grants A,B,A,B.
  - dram_wr_en @ issue cycles of B with din=b_wdata=0x12345678.
- Outstanding limit, MAX_OUTSTD=4:
  - A issues 4 reads with no returns; 5th a_req sees a_gnt=0, while a B write is granted the same cycle.
  - one rd_valid -> A read granted the following cycle.
- Interleaved routing: reads issued A,B,B,A; returns dout=1,2,3,4 -> a_rdata=1, b_rdata=2, b_rdata=3, a_rdata=4, in order, one cycle after each return.
- Spurious return: rd_valid with nothing outstanding -> no rvalid, rd_err=1 sticky, cnt stays 0; next read still works.
- Reset mid-flight: 2 reads outstanding, then rst=0 for 2 cycles.
  - all outputs 0 immediately (asynchronously); cnt=0.
  - a late rd_valid after release sets rd_err=1.
